// File: rtl/window_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_stats_pkg
//  Description : Shared defaults, window state encoding and the record sum
//                width helper for the window_stats block.
//  Revision    : 1.0  - initial release
// ============================================================================
package window_stats_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_WINDOW     = 16;
    localparam int DEFAULT_DROP_WIDTH = 16;

    // Window accumulator state: EMPTY holds no samples, ACCUM holds
    // 1..WINDOW-1 samples.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // A window of WINDOW unsigned samples needs $clog2(WINDOW) extra bits
    // on top of the sample width to never overflow.
    function automatic int sum_width(input int data_width, input int window);
        return data_width + $clog2(window);
    endfunction

endpackage : window_stats_pkg
`default_nettype wire

// File: rtl/stats_queue.sv
`default_nettype none
// ============================================================================
//  Module      : stats_queue
//  Description : Two-entry registered FIFO for window records. The head entry
//                is a register so the consumer sees stable, registered data.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                push, push_data - record offered for enqueue
//                push_ok         - record accepted this cycle
//                pop             - consumer takes the head (ignored if empty)
//                head, valid     - head record and its valid flag
//  Revision    : 1.0  - initial release
// ============================================================================
module stats_queue #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push_ok;

    assign w_pop     = pop && (r_count != 2'd0);
    // A full queue still takes a record when the head leaves the same cycle.
    assign w_push_ok = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (w_pop) begin
            // With one entry left, a simultaneous push lands directly in the
            // head; with two, the tail advances and the new record refills it.
            r_head <= (w_push_ok && (r_count == 2'd1)) ? push_data : r_tail;
            if (w_push_ok) begin
                r_tail <= push_data;
            end else begin
                r_count <= r_count - 2'd1;
            end
        end else if (w_push_ok) begin
            if (r_count == 2'd0) begin
                r_head <= push_data;
            end else begin
                r_tail <= push_data;
            end
            r_count <= r_count + 2'd1;
        end
    end

    assign push_ok = w_push_ok;
    assign head    = r_head;
    assign valid   = (r_count != 2'd0);

endmodule : stats_queue
`default_nettype wire

// File: rtl/window_stats.sv
`default_nettype none
// ============================================================================
//  Module      : window_stats
//  Description : Accumulates fixed-size windows of unsigned samples into
//                {sum, min, max, count} records and presents them through a
//                2-entry queue on a valid/ready port. Samples are never
//                refused; records that cannot be queued are dropped and
//                counted (saturating).
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                in_data, in_valid - sample stream (no backpressure)
//                flush             - pulse, closes a partial window
//                out_sum/min/max/count, out_valid, out_ready - record port
//                drop_count        - dropped records, saturating
//                busy              - window non-empty or queue non-empty
//  Config      : WINDOW_STATS_MINMAX_EN - when defined, min/max are tracked
//                and queued; otherwise out_min/out_max are tied to zero.
//  Revision    : 1.0  - initial release
// ============================================================================
module window_stats
    import window_stats_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WINDOW     = DEFAULT_WINDOW,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, WINDOW),
    parameter int CNT_WIDTH  = $clog2(WINDOW + 1),
    parameter int DROP_WIDTH = DEFAULT_DROP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  flush,
    output logic [SUM_WIDTH-1:0]  out_sum,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  busy
);

`ifdef WINDOW_STATS_MINMAX_EN
    localparam int c_REC_WIDTH = SUM_WIDTH + 2 * DATA_WIDTH + CNT_WIDTH;
`else
    localparam int c_REC_WIDTH = SUM_WIDTH + CNT_WIDTH;
`endif

    // ------------------------------------------------------------------
    // Window state and accumulators
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [SUM_WIDTH-1:0]  r_sum;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DROP_WIDTH-1:0] r_drop;

    logic                  w_start;
    logic [SUM_WIDTH-1:0]  w_acc_sum;
    logic [CNT_WIDTH-1:0]  w_acc_cnt;
    logic [SUM_WIDTH-1:0]  w_rec_sum;
    logic [CNT_WIDTH-1:0]  w_rec_cnt;
    logic                  w_close_full;
    logic                  w_close_flush;
    logic                  w_close;

    logic [c_REC_WIDTH-1:0] w_rec;
    logic [c_REC_WIDTH-1:0] w_head;
    logic                   w_push_ok;
    logic                   w_q_valid;

    // First sample of a window overwrites the accumulators instead of adding.
    assign w_start   = (r_state == EMPTY);
    assign w_acc_sum = w_start ? SUM_WIDTH'(in_data) : (r_sum + SUM_WIDTH'(in_data));
    assign w_acc_cnt = w_start ? CNT_WIDTH'(1) : (r_cnt + CNT_WIDTH'(1));

    // The record always includes a same-cycle sample.
    assign w_rec_sum = in_valid ? w_acc_sum : r_sum;
    assign w_rec_cnt = in_valid ? w_acc_cnt : r_cnt;

    assign w_close_full  = in_valid && (r_cnt == CNT_WIDTH'(WINDOW - 1));
    assign w_close_flush = flush && ((r_cnt != '0) || in_valid);
    // A flush coinciding with a full close collapses into one record.
    assign w_close       = w_close_full || w_close_flush;

`ifdef WINDOW_STATS_MINMAX_EN
    logic [DATA_WIDTH-1:0] r_min;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] w_acc_min;
    logic [DATA_WIDTH-1:0] w_acc_max;
    logic [DATA_WIDTH-1:0] w_rec_min;
    logic [DATA_WIDTH-1:0] w_rec_max;

    assign w_acc_min = (w_start || (in_data < r_min)) ? in_data : r_min;
    assign w_acc_max = (w_start || (in_data > r_max)) ? in_data : r_max;
    assign w_rec_min = in_valid ? w_acc_min : r_min;
    assign w_rec_max = in_valid ? w_acc_max : r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '0;
            r_max <= '0;
        end else if (w_close) begin
            r_min <= '0;
            r_max <= '0;
        end else if (in_valid) begin
            r_min <= w_acc_min;
            r_max <= w_acc_max;
        end
    end

    assign w_rec   = {w_rec_sum, w_rec_min, w_rec_max, w_rec_cnt};
    assign out_sum = w_head[c_REC_WIDTH-1 -: SUM_WIDTH];
    assign out_min = w_head[2*DATA_WIDTH+CNT_WIDTH-1 -: DATA_WIDTH];
    assign out_max = w_head[DATA_WIDTH+CNT_WIDTH-1 -: DATA_WIDTH];
`else
    assign w_rec   = {w_rec_sum, w_rec_cnt};
    assign out_sum = w_head[c_REC_WIDTH-1 -: SUM_WIDTH];
    assign out_min = '0;
    assign out_max = '0;
`endif

    assign out_count = w_head[CNT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_close) begin
            w_state_nxt = EMPTY;
        end else if (in_valid) begin
            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_close) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (in_valid) begin
            r_sum <= w_acc_sum;
            r_cnt <= w_acc_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Record queue and drop accounting
    // ------------------------------------------------------------------
    stats_queue #(
        .WIDTH (c_REC_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_close),
        .push_data (w_rec),
        .push_ok   (w_push_ok),
        .pop       (out_ready),
        .head      (w_head),
        .valid     (w_q_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_close && !w_push_ok && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_WIDTH'(1);
        end
    end

    assign out_valid  = w_q_valid;
    assign drop_count = r_drop;
    assign busy       = (r_state == ACCUM) || w_q_valid;

endmodule : window_stats
`default_nettype wire
